fp_wb_merge: RTL and testbench
==============================

FP_WB_MERGE -- requirements
Module: fp_wb_merge

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 3, giving the number of FP functional units merged (2..8).
REQ-002 SHALL have parameter FLEN, default 64, giving the result data width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port unit_done, input, NUM_UNITS bits: per-unit result valid.
REQ-006 SHALL have port unit_id, input, NUM_UNITS x id_t: per-unit instruction ID.
REQ-007 SHALL have port unit_rd, input, NUM_UNITS x FLEN: per-unit result data.
REQ-008 SHALL have port unit_ack, output, NUM_UNITS bits: result accepted this cycle.
REQ-009 SHALL have port wb_done, output, 1 bit: merged result valid toward the FP writeback port.
REQ-010 SHALL have port wb_id, output, id_t: ID of the merged result.
REQ-011 SHALL have port wb_rd, output, FLEN bits: data of the merged result.
REQ-012 SHALL have port wb_ack, input, 1 bit: the writeback port has consumed the merged result.

Function
REQ-013 SHALL hold one holding register (valid, id, rd) per unit; transfer occurs at the clock edge when unit_done and unit_ack are both high.
REQ-014 SHALL drive unit_ack[i] = !hold_valid[i] OR (grant[i] AND out_load), combinationally, so each unit sustains one result per cycle when granted.
REQ-015 SHALL hold one output register; out_load = !wb_done OR wb_ack, so draining and loading in the same cycle gives one result per cycle.
REQ-016 SHALL grant, when out_load is high, exactly one valid holding register, round-robin, starting from the unit after the last granted one.
REQ-017 SHALL copy the granted entry into the output register; wb_done/wb_id/wb_rd are driven only from the output register.
REQ-018 SHALL give a minimum latency of 2 cycles: unit accepted at edge N, visible on wb_done from edge N+1 to edge N+2.
REQ-019 SHALL hold wb_id/wb_rd stable while wb_done is high and wb_ack is low.
REQ-020 SHALL clear a holding register on grant unless it is refilled in the same cycle, in which case it keeps valid with the new contents.
REQ-021 SHALL leave the round-robin pointer unchanged in cycles with no grant.
REQ-022 SHALL treat wb_ack while wb_done is low as no effect.
REQ-023 SHALL preserve per-unit result order; no ordering is implied across units.

Reset
REQ-024 SHALL, while rst_n is low, force all hold_valid to 0, wb_done to 0, wb_id/wb_rd to 0, the round-robin pointer to unit 0 highest priority, and unit_ack to all ones.
REQ-025 SHALL discard in-flight entries on reset mid-operation; no result is emitted after rst_n rises until a new unit_done.

Configuration
REQ-026 SHALL, with FP_WB_MERGE_STATS_EN defined, add output port conflict_count (16 bits) counting cycles with two or more valid holding registers; the count saturates at 0xFFFF and resets to 0.
REQ-027 SHALL, without FP_WB_MERGE_STATS_EN defined, omit the port and the counter; all other behaviour is identical.

Structure
REQ-028 SHALL take id_t from cva5_types; SHALL add fp_unit_result_t (id_t id, FLEN rd) to the shared FP package and use it for the holding and output registers.
REQ-029 SHALL implement arbitration in one sub-module fp_wb_rr_arbiter (request vector, advance strobe, one-hot grant, registered pointer).

Verification
REQ-030 SHALL cover: single unit 1 with done, id=5, rd=0x3FF0000000000000, wb_ack tied high -> wb_done high 2 cycles later with id 5 and that rd; unit_ack[1] stays high.
REQ-031 SHALL cover: units 0, 1 and 2 done in the same cycle with ids 1, 2 and 3, wb_ack high -> wb_id sequence 1, 2, 3 on consecutive cycles, pointer ending at unit 0.
REQ-032 SHALL cover: wb_ack low for 4 cycles with all units streaming -> wb_* stable, each unit_ack low after its holding register fills, and no loss or duplication after wb_ack rises.
REQ-033 SHALL cover: unit 0 streams ids 10, 11 and 12 back-to-back while unit 2 is idle, wb_ack high -> output 10, 11, 12 at one result per cycle.
REQ-034 SHALL cover: rst_n pulsed low with 2 holding registers and the output register valid -> wb_done 0 immediately, no stale results afterward, and conflict_count 0 when FP_WB_MERGE_STATS_EN is defined.
REQ-035 SHALL cover: with FP_WB_MERGE_STATS_EN defined, a 70000-cycle conflict -> conflict_count saturates at 0xFFFF.

Source files
------------

// File: rtl/cva5_types.sv
// Slice of the shared CVA5 type package: the instruction ID type used across units.
package cva5_types;
  localparam int MAX_IDS      = 32;
  localparam int LOG2_MAX_IDS = $clog2(MAX_IDS);

  typedef logic [LOG2_MAX_IDS-1:0] id_t;
endpackage

// File: rtl/fp_wb_merge_pkg.sv
// Shared FP writeback package: result record carried by holding and output registers.
package fp_wb_merge_pkg;
  import cva5_types::*;

  // Records are sized for the widest supported FLEN; narrower builds zero-extend.
  localparam int FP_FLEN_MAX = 64;

  typedef struct packed {
    id_t                    id;
    logic [FP_FLEN_MAX-1:0] rd;
  } fp_unit_result_t;

  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction
endpackage

// File: rtl/fp_wb_rr_arbiter.sv
// Round-robin one-hot arbiter; the pointer marks the highest-priority requester
// and moves past the winner only on cycles where a grant is actually taken.
module fp_wb_rr_arbiter
  import fp_wb_merge_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [N-1:0] o_grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_next;
  int            w_best;
  int            w_dist [N];

  // Distance from the pointer ranks requesters; the closest valid one wins.
  always_comb begin
    w_best     = N;
    o_grant    = '0;
    w_ptr_next = r_ptr;
    for (int i = 0; i < N; i++) begin
      w_dist[i] = wrap_idx(i + N - int'(r_ptr), N);
      if (i_req[i] && (w_dist[i] < w_best)) w_best = w_dist[i];
    end
    for (int i = 0; i < N; i++) begin
      o_grant[i] = i_req[i] && (w_dist[i] == w_best);
      if (o_grant[i]) w_ptr_next = PW'(wrap_idx(i + 1, N));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && (|i_req)) begin
      r_ptr <= w_ptr_next;
    end
  end
endmodule

// File: rtl/fp_wb_merge.sv
// Merges NUM_UNITS FP result streams into one writeback port via per-unit holding registers.
// Optional build define FP_WB_MERGE_STATS_EN adds the conflict_count statistics output.
module fp_wb_merge
  import cva5_types::*;
  import fp_wb_merge_pkg::*;
#(
  parameter int NUM_UNITS = 3,
  parameter int FLEN      = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_UNITS-1:0]           unit_done,
  input  id_t  [NUM_UNITS-1:0]           unit_id,
  input  logic [NUM_UNITS-1:0][FLEN-1:0] unit_rd,
  output logic [NUM_UNITS-1:0]           unit_ack,
  output logic                           wb_done,
  output id_t                            wb_id,
  output logic [FLEN-1:0]                wb_rd,
  input  logic                           wb_ack
`ifdef FP_WB_MERGE_STATS_EN
  ,
  output logic [15:0]                    conflict_count
`endif
);
  fp_unit_result_t      r_hold [NUM_UNITS];
  logic [NUM_UNITS-1:0] r_hold_valid;
  fp_unit_result_t      r_out;
  logic                 r_wb_done;
  logic [NUM_UNITS-1:0] w_grant;
  logic                 w_out_load;
  fp_unit_result_t      w_sel;

  assign w_out_load = !r_wb_done || wb_ack;

  fp_wb_rr_arbiter #(.N(NUM_UNITS)) u_arb (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (r_hold_valid),
    .i_advance (w_out_load),
    .o_grant   (w_grant)
  );

  always_comb begin
    w_sel    = '0;
    unit_ack = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (w_grant[i]) w_sel = r_hold[i];
      // A granted slot frees up this cycle, so its unit may refill it at the same edge.
      unit_ack[i] = !r_hold_valid[i] || (w_grant[i] && w_out_load);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= '0;
      for (int i = 0; i < NUM_UNITS; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (unit_done[i] && unit_ack[i]) begin
          r_hold_valid[i] <= 1'b1;
          r_hold[i].id    <= unit_id[i];
          r_hold[i].rd    <= FP_FLEN_MAX'(unit_rd[i]);
        end else if (w_grant[i] && w_out_load) begin
          r_hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_done <= 1'b0;
      r_out     <= '0;
    end else if (w_out_load) begin
      r_wb_done <= |w_grant;
      if (|w_grant) r_out <= w_sel;
    end
  end

  assign wb_done = r_wb_done;
  assign wb_id   = r_out.id;
  assign wb_rd   = r_out.rd[FLEN-1:0];

`ifdef FP_WB_MERGE_STATS_EN
  logic [15:0] r_conflict_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_count <= '0;
    end else if (($countones(r_hold_valid) >= 2) && (r_conflict_count != 16'hFFFF)) begin
      r_conflict_count <= r_conflict_count + 16'd1;
    end
  end

  assign conflict_count = r_conflict_count;
`endif
endmodule

// File: tb/tb_fp_wb_merge.sv
// Self-checking bench for fp_wb_merge: behavioural model, per-unit order scoreboard and directed cases.
module tb_fp_wb_merge;
  import cva5_types::*;

  localparam int N    = 3;
  localparam int FLEN = 64;
  localparam int IW   = $bits(id_t);

  typedef logic [IW+FLEN-1:0] ent_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [N-1:0]           unit_done = '0;
  id_t  [N-1:0]           unit_id = '0;
  logic [N-1:0][FLEN-1:0] unit_rd = '0;
  logic [N-1:0]           unit_ack;
  logic                   wb_done;
  id_t                    wb_id;
  logic [FLEN-1:0]        wb_rd;
  logic                   wb_ack = 1'b0;
`ifdef FP_WB_MERGE_STATS_EN
  logic [15:0]            conflict_count;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  fp_wb_merge #(.NUM_UNITS(N), .FLEN(FLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .unit_done (unit_done),
    .unit_id   (unit_id),
    .unit_rd   (unit_rd),
    .unit_ack  (unit_ack),
    .wb_done   (wb_done),
    .wb_id     (wb_id),
    .wb_rd     (wb_rd),
    .wb_ack    (wb_ack)
`ifdef FP_WB_MERGE_STATS_EN
    ,
    .conflict_count (conflict_count)
`endif
  );

  // Model: one pending slot per unit, one output slot, and the last unit served.
  bit              m_hv [N];
  id_t             m_hid [N];
  logic [FLEN-1:0] m_hrd [N];
  int              m_last;
  bit              m_wbv;
  id_t             m_wid;
  logic [FLEN-1:0] m_wrd;
  bit              last_acc [N];
  ent_t            sb [N][$];
  int              obs_id [$];
  int              obs_cyc [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_hv[i] = 0;
      last_acc[i] = 0;
      sb[i].delete();
    end
    m_last = N - 1;
    m_wbv  = 0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    int g;
    bit ol;
    bit found;
    logic [N-1:0] eack;
    #1;
    ol = !m_wbv || wb_ack;
    g = -1;
    if (ol) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (g < 0 && m_hv[j]) g = j;
      end
    end
    for (int i = 0; i < N; i++) eack[i] = !m_hv[i] || (g == i);
    chk("unit_ack", 64'(unit_ack), 64'(eack));
    chk("wb_done", 64'(wb_done), 64'(m_wbv));
    if (m_wbv) begin
      chk("wb_id", 64'(wb_id), 64'(m_wid));
      chk("wb_rd", wb_rd, m_wrd);
    end
    if (wb_done && wb_ack) begin
      obs_id.push_back(int'(wb_id));
      obs_cyc.push_back(cyc);
      found = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && sb[i].size() > 0 && sb[i][0] == {wb_id, wb_rd}) begin
          void'(sb[i].pop_front());
          found = 1;
        end
      end
      checks++;
      if (!found) begin
        failures++;
        $display("FAIL scoreboard: unexpected result id=%0h rd=%0h (cycle %0d)", wb_id, wb_rd, cyc);
      end
    end
    @(posedge clk);
    if (ol) begin
      if (g >= 0) begin
        m_wbv = 1;
        m_wid = m_hid[g];
        m_wrd = m_hrd[g];
        m_last = g;
      end else begin
        m_wbv = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (g == i) m_hv[i] = 0;
      last_acc[i] = unit_done[i] && eack[i];
      if (last_acc[i]) begin
        m_hv[i]  = 1;
        m_hid[i] = unit_id[i];
        m_hrd[i] = unit_rd[i];
        sb[i].push_back({unit_id[i], unit_rd[i]});
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    unit_done = '0;
    wb_ack = 1'b0;
    #1;
    chk("rst_wb_done", 64'(wb_done), 64'd0);
    chk("rst_wb_id", 64'(wb_id), 64'd0);
    chk("rst_wb_rd", wb_rd, 64'd0);
    chk("rst_unit_ack", 64'(unit_ack), 64'({N{1'b1}}));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present new work where the previous offer was taken or nothing was offered; hold otherwise.
  task automatic drive_rand(input int pct);
    for (int i = 0; i < N; i++) begin
      if (!unit_done[i] || last_acc[i]) begin
        unit_done[i] = ($urandom_range(0, 99) < pct);
        unit_id[i]   = id_t'($urandom);
        unit_rd[i]   = {$urandom, $urandom};
      end
    end
  endtask

  task automatic drain();
    unit_done = '0;
    wb_ack = 1'b1;
    repeat (10) step();
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Single result from unit 1 appears two edges after acceptance.
    wb_ack = 1'b1;
    unit_done = 3'b010;
    unit_id[1] = id_t'(5);
    unit_rd[1] = 64'h3FF0000000000000;
    #1 chk("single_ack1", 64'(unit_ack[1]), 64'd1);
    step();
    unit_done = '0;
    step();
    #1;
    chk("single_wb_done", 64'(wb_done), 64'd1);
    chk("single_wb_id", 64'(wb_id), 64'd5);
    chk("single_wb_rd", wb_rd, 64'h3FF0000000000000);
    chk("single_ack1_after", 64'(unit_ack[1]), 64'd1);
    repeat (4) step();

    // Three simultaneous results drain in round-robin order from unit 0.
    do_reset();
    obs_id.delete(); obs_cyc.delete();
    wb_ack = 1'b1;
    unit_done = 3'b111;
    unit_id[0] = id_t'(1); unit_id[1] = id_t'(2); unit_id[2] = id_t'(3);
    unit_rd[0] = 64'h100; unit_rd[1] = 64'h200; unit_rd[2] = 64'h300;
    step();
    unit_done = '0;
    repeat (6) step();
    chk("rr_count", 64'(obs_id.size()), 64'd3);
    if (obs_id.size() >= 3) begin
      chk("rr_id0", 64'(obs_id[0]), 64'd1);
      chk("rr_id1", 64'(obs_id[1]), 64'd2);
      chk("rr_id2", 64'(obs_id[2]), 64'd3);
      chk("rr_back_to_back", 64'(obs_cyc[2] - obs_cyc[0]), 64'd2);
    end

    // Pointer must now sit at unit 0: unit 0 beats unit 2.
    obs_id.delete(); obs_cyc.delete();
    unit_done = 3'b101;
    unit_id[0] = id_t'(7); unit_id[2] = id_t'(8);
    step();
    unit_done = '0;
    repeat (6) step();
    chk("ptr_count", 64'(obs_id.size()), 64'd2);
    if (obs_id.size() >= 2) begin
      chk("ptr_first", 64'(obs_id[0]), 64'd7);
      chk("ptr_second", 64'(obs_id[1]), 64'd8);
    end

    // Unit 0 streams back-to-back at one result per cycle.
    obs_id.delete(); obs_cyc.delete();
    for (int k = 0; k < 3; k++) begin
      unit_done = 3'b001;
      unit_id[0] = id_t'(10 + k);
      unit_rd[0] = 64'hA000 + 64'(k);
      step();
    end
    unit_done = '0;
    repeat (6) step();
    chk("stream_count", 64'(obs_id.size()), 64'd3);
    if (obs_id.size() >= 3) begin
      chk("stream_id0", 64'(obs_id[0]), 64'd10);
      chk("stream_id1", 64'(obs_id[1]), 64'd11);
      chk("stream_id2", 64'(obs_id[2]), 64'd12);
      chk("stream_rate", 64'(obs_cyc[2] - obs_cyc[0]), 64'd2);
    end

    // All units streaming, then a 4-cycle writeback stall.
    wb_ack = 1'b1;
    repeat (6) begin drive_rand(100); step(); end
    wb_ack = 1'b0;
    for (int s = 0; s < 4; s++) begin
      drive_rand(100);
      if (s == 3) #1 chk("stall_ack_all_low", 64'(unit_ack), 64'd0);
      step();
    end
    wb_ack = 1'b1;
    repeat (8) begin drive_rand(100); step(); end
    drain();

    // Random traffic at several load / backpressure mixes.
    for (int ph = 0; ph < 3; ph++) begin
      repeat (700) begin
        drive_rand(ph == 0 ? 30 : (ph == 1 ? 70 : 95));
        wb_ack = ($urandom_range(0, 99) < (ph == 2 ? 40 : 80));
        step();
      end
    end
    drain();
    for (int i = 0; i < N; i++) chk("drain_empty", 64'(sb[i].size()), 64'd0);

    // Reset with two holding registers and the output register occupied.
    wb_ack = 1'b0;
    unit_done = 3'b100; unit_id[2] = id_t'(20); unit_rd[2] = 64'hC0;
    step();
    unit_done = 3'b011; unit_id[0] = id_t'(21); unit_id[1] = id_t'(22);
    step();
    unit_done = '0;
    #1 chk("pre_rst_wb_done", 64'(wb_done), 64'd1);
    do_reset();
    obs_id.delete(); obs_cyc.delete();
    wb_ack = 1'b1;
    repeat (6) step();
    chk("post_rst_quiet", 64'(obs_id.size()), 64'd0);
`ifdef FP_WB_MERGE_STATS_EN
    chk("conflict_rst", 64'(conflict_count), 64'd0);
    wb_ack = 1'b0;
    unit_done = 3'b011;
    repeat (3) step();
    repeat (70000) @(posedge clk);
    @(negedge clk);
    #1 chk("conflict_sat", 64'(conflict_count), 64'hFFFF);
    do_reset();
    #1 chk("conflict_cleared", 64'(conflict_count), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
